// File: rtl/adc_dbg_pkg.sv
// Shared types and constants for the ADC snapshot-capture / UART dump path.
package adc_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        TX_HDR0,
        TX_HDR1,
        TX_DATA,
        TX_CHK
    } state_t;

    localparam logic [7:0] HDR0_DEFAULT = 8'hA5;
    localparam logic [7:0] HDR1_DEFAULT = 8'h5A;

    // 65 MHz / 115200 baud, rounded
    localparam int CLKS_PER_BIT_115200 = 564;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser; ready rises in the last cycle of the stop bit so bytes can be chained gap-free.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 564
) (
    input  logic       CLK_65M,
    input  logic       RST_n,
    input  logic [7:0] data,
    input  logic       load,
    output logic       ready,
    output logic       tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          active;
    logic [3:0]    bit_idx;
    logic [BW-1:0] baud_cnt;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign ready   = !active || ((bit_idx == 4'd9) && bit_end);

    // bit_idx: 0 = start bit, 1..8 = data LSB first, 9 = stop bit
    always_ff @(posedge CLK_65M) begin
        if (!RST_n) begin
            active   <= 1'b0;
            bit_idx  <= 4'd0;
            baud_cnt <= '0;
            shreg    <= 8'd0;
            tx       <= 1'b1;
        end else if (load && ready) begin
            active   <= 1'b1;
            shreg    <= data;
            bit_idx  <= 4'd0;
            baud_cnt <= '0;
            tx       <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active  <= 1'b0;
                    bit_idx <= 4'd0;
                    tx      <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd8) begin
                        tx <= 1'b1;
                    end else begin
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_capture_uart.sv
// Captures DEPTH (optionally decimated) samples on start, then dumps HDR0,HDR1,data...,checksum over UART.
module adc_capture_uart
    import adc_dbg_pkg::*;
#(
    parameter int         DEPTH        = 256,
    parameter int         DECIM        = 1,
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter logic [7:0] HDR0         = HDR0_DEFAULT,
    parameter logic [7:0] HDR1         = HDR1_DEFAULT
) (
    input  logic       CLK_65M,
    input  logic       RST_n,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       start,
    output logic       uart_tx,
    output logic       busy,
    output logic       done
);

    localparam int            AW        = addr_width(DEPTH);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [7:0]    DEC_LAST  = 8'(DECIM - 1);

    state_t        state;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    dec_cnt;
    logic [7:0]    checksum;
    logic [7:0]    rd_data;
    logic [7:0]    tx_data;
    logic          chk_sent;
    logic          tx_load;
    logic          tx_ready;
    logic          wr_en;

    logic [7:0] mem [DEPTH];

    assign wr_en = (state == CAPTURE) && sample_valid && (dec_cnt == 8'd0);

    // Simple dual-port RAM; the read runs every cycle so the next data byte is ready well before it is loaded.
    always_ff @(posedge CLK_65M) begin
        if (wr_en) begin
            mem[wr_addr] <= sample_in;
        end
        rd_data <= mem[rd_addr];
    end

    always_comb begin
        tx_load = 1'b0;
        tx_data = HDR0;
        case (state)
            TX_HDR0: begin
                tx_load = tx_ready;
                tx_data = HDR0;
            end
            TX_HDR1: begin
                tx_load = tx_ready;
                tx_data = HDR1;
            end
            TX_DATA: begin
                tx_load = tx_ready;
                tx_data = rd_data;
            end
            TX_CHK: begin
                tx_load = tx_ready && !chk_sent;
                tx_data = checksum;
            end
            default: begin
                tx_load = 1'b0;
                tx_data = HDR0;
            end
        endcase
    end

    // Each TX state names the byte to hand over next; TX_CHK then waits for the checksum's stop bit to end.
    always_ff @(posedge CLK_65M) begin
        if (!RST_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            dec_cnt  <= 8'd0;
            checksum <= 8'd0;
            chk_sent <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CAPTURE;
                        busy     <= 1'b1;
                        wr_addr  <= '0;
                        rd_addr  <= '0;
                        dec_cnt  <= 8'd0;
                        checksum <= 8'd0;
                        chk_sent <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (sample_valid) begin
                        dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
                        if (dec_cnt == 8'd0) begin
                            if (wr_addr == ADDR_LAST) begin
                                state <= TX_HDR0;
                            end else begin
                                wr_addr <= wr_addr + 1'b1;
                            end
                        end
                    end
                end
                TX_HDR0: begin
                    if (tx_load) begin
                        state <= TX_HDR1;
                    end
                end
                TX_HDR1: begin
                    if (tx_load) begin
                        state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_load) begin
                        checksum <= checksum + rd_data;
                        rd_addr  <= rd_addr + 1'b1;
                        if (rd_addr == ADDR_LAST) begin
                            state <= TX_CHK;
                        end
                    end
                end
                TX_CHK: begin
                    if (tx_load) begin
                        chk_sent <= 1'b1;
                    end else if (chk_sent && tx_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .CLK_65M(CLK_65M),
        .RST_n  (RST_n),
        .data   (tx_data),
        .load   (tx_load),
        .ready  (tx_ready),
        .tx     (uart_tx)
    );

endmodule

// File: tb/tb_adc_capture_uart.sv
// Bench for adc_capture_uart: two small instances (DECIM=1 and DECIM=3) against a frame-level reference model.
module tb_adc_capture_uart;

    localparam int TB_DEPTH = 4;
    localparam int TB_CPB   = 4;
    localparam int BYTE_CYC = 10 * TB_CPB;
    localparam int N        = 2048;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       start_d1;
    logic       start_d3;
    logic       tx_d1, busy_d1, done_d1;
    logic       tx_d3, busy_d3, done_d3;

    int checks   = 0;
    int failures = 0;
    int cur_t    = 0;

    bit         st_start [N];
    bit         st_valid [N];
    bit         st_rst   [N];
    logic [7:0] st_data  [N];
    bit         ex_busy  [N+1];
    bit         ex_done  [N+1];

    logic [7:0] exp_q[$];
    int         exp_t[$];
    int         done_iters[$];
    int         frame_iters[$];

    always #5 clk = ~clk;

    adc_capture_uart #(.DEPTH(TB_DEPTH), .DECIM(1), .CLKS_PER_BIT(TB_CPB)) dut_d1 (
        .CLK_65M     (clk),
        .RST_n       (rst_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .start       (start_d1),
        .uart_tx     (tx_d1),
        .busy        (busy_d1),
        .done        (done_d1)
    );

    adc_capture_uart #(.DEPTH(TB_DEPTH), .DECIM(3), .CLKS_PER_BIT(TB_CPB)) dut_d3 (
        .CLK_65M     (clk),
        .RST_n       (rst_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .start       (start_d3),
        .uart_tx     (tx_d3),
        .busy        (busy_d3),
        .done        (done_d3)
    );

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, cur_t, actual, expected);
        end
    endtask

    task automatic clear_stim();
        for (int t = 0; t < N; t++) begin
            st_start[t] = 1'b0;
            st_valid[t] = 1'b1;
            st_rst[t]   = 1'b0;
            st_data[t]  = 8'($urandom_range(0, 255));
        end
    endtask

    // Iteration t drives inputs seen by the next edge; index t+1 holds what is observed after that edge.
    task automatic build_model(input int decim, input int len);
        int         mstate;
        int         vcnt;
        int         kept;
        int         d;
        int         f0;
        logic [7:0] cap [TB_DEPTH];
        logic [7:0] sum;
        exp_q.delete();
        exp_t.delete();
        done_iters.delete();
        frame_iters.delete();
        mstate     = 0;
        vcnt       = 0;
        kept       = 0;
        d          = 0;
        ex_busy[0] = 1'b0;
        ex_done[0] = 1'b0;
        for (int t = 0; t < len; t++) begin
            ex_busy[t+1] = 1'b0;
            ex_done[t+1] = 1'b0;
            if (st_rst[t]) begin
                mstate = 0;
                while (exp_t.size() > 0 && exp_t[$] + BYTE_CYC - 1 >= t + 1) begin
                    void'(exp_t.pop_back());
                    void'(exp_q.pop_back());
                end
            end else if (mstate == 0) begin
                if (st_start[t]) begin
                    mstate       = 1;
                    vcnt         = 0;
                    kept         = 0;
                    ex_busy[t+1] = 1'b1;
                end
            end else if (mstate == 1) begin
                ex_busy[t+1] = 1'b1;
                if (st_valid[t]) begin
                    if (vcnt % decim == 0) begin
                        cap[kept] = st_data[t];
                        kept++;
                    end
                    vcnt++;
                end
                if (kept == TB_DEPTH) begin
                    f0  = t + 2;
                    sum = 8'd0;
                    frame_iters.push_back(f0);
                    exp_q.push_back(8'hA5);
                    exp_t.push_back(f0);
                    exp_q.push_back(8'h5A);
                    exp_t.push_back(f0 + BYTE_CYC);
                    for (int k = 0; k < TB_DEPTH; k++) begin
                        sum = sum + cap[k];
                        exp_q.push_back(cap[k]);
                        exp_t.push_back(f0 + (2 + k) * BYTE_CYC);
                    end
                    exp_q.push_back(sum);
                    exp_t.push_back(f0 + (TB_DEPTH + 2) * BYTE_CYC);
                    d      = f0 + (TB_DEPTH + 3) * BYTE_CYC;
                    mstate = 2;
                end
            end else begin
                if (t + 1 == d) begin
                    ex_done[t+1] = 1'b1;
                    done_iters.push_back(d);
                    mstate = 0;
                end else begin
                    ex_busy[t+1] = 1'b1;
                end
            end
        end
    endtask

    task automatic run_scenario(input int which, input int len);
        int         rx_pos;
        int         rx_start;
        int         k;
        bit         rx_bad;
        logic [9:0] rx_bits;
        logic       tx;
        logic       bsy;
        logic       dne;
        rx_pos   = -1;
        rx_start = 0;
        rx_bad   = 1'b0;
        rx_bits  = 10'd0;
        for (int t = 0; t < len; t++) begin
            @(posedge clk);
            #1;
            rst_n        = !st_rst[t];
            start_d1     = (which == 1) ? st_start[t] : 1'b0;
            start_d3     = (which == 3) ? st_start[t] : 1'b0;
            sample_in    = st_data[t];
            sample_valid = st_valid[t];
            @(negedge clk);
            cur_t = t;
            tx    = (which == 1) ? tx_d1 : tx_d3;
            bsy   = (which == 1) ? busy_d1 : busy_d3;
            dne   = (which == 1) ? done_d1 : done_d3;
            check_eq("busy", 32'(bsy), 32'(ex_busy[t]));
            check_eq("done", 32'(dne), 32'(ex_done[t]));
            if (t > 0 && st_rst[t-1]) begin
                rx_pos = -1;
                check_eq("tx_after_reset", 32'(tx), 32'd1);
            end
            if (rx_pos < 0 && tx == 1'b0) begin
                rx_pos   = 0;
                rx_start = t;
                rx_bad   = 1'b0;
            end
            if (rx_pos >= 0) begin
                k = rx_pos / TB_CPB;
                if (rx_pos % TB_CPB == 0) begin
                    rx_bits[k] = tx;
                end else if (tx !== rx_bits[k]) begin
                    rx_bad = 1'b1;
                end
                rx_pos++;
                if (rx_pos == BYTE_CYC) begin
                    rx_pos = -1;
                    check_eq("bit_stable", 32'(rx_bad), 32'd0);
                    check_eq("stop_bit", 32'(rx_bits[9]), 32'd1);
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_byte_start", 32'(rx_start), 32'hFFFF_FFFF);
                    end else begin
                        check_eq("byte", 32'(rx_bits[8:1]), 32'(exp_q.pop_front()));
                        check_eq("byte_start", 32'(rx_start), 32'(exp_t.pop_front()));
                    end
                end
            end
        end
        check_eq("missing_bytes", 32'(exp_q.size()), 32'd0);
        check_eq("rx_idle_at_end", 32'(rx_pos), 32'hFFFF_FFFF);
        start_d1 = 1'b0;
        start_d3 = 1'b0;
    endtask

    initial begin
        int d0;
        int d1;
        int d2;
        int s;
        int rst_t;
        int len;

        rst_n        = 1'b0;
        start_d1     = 1'b0;
        start_d3     = 1'b0;
        sample_in    = 8'd0;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_tx_d1", 32'(tx_d1), 32'd1);
        check_eq("reset_busy_d1", 32'(busy_d1), 32'd0);
        check_eq("reset_done_d1", 32'(done_d1), 32'd0);
        check_eq("reset_tx_d3", 32'(tx_d3), 32'd1);
        check_eq("reset_busy_d3", 32'(busy_d3), 32'd0);
        check_eq("reset_done_d3", 32'(done_d3), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // DECIM=1: ramp frame, ignored starts, FF wrap frame, sparse-valid frame, reset mid-data, fresh frame.
        clear_stim();
        st_start[2] = 1'b1;
        for (int k = 0; k < TB_DEPTH; k++) st_data[3+k] = 8'(10 + k);
        build_model(1, N);
        d0 = done_iters[0];
        st_start[100]  = 1'b1;
        st_start[d0-1] = 1'b1;
        st_start[d0]   = 1'b1;
        for (int k = 0; k < TB_DEPTH; k++) st_data[d0+1+k] = 8'hFF;
        build_model(1, N);
        d1 = done_iters[1];
        s  = d1 + 5;
        st_start[s] = 1'b1;
        for (int t = s + 1; t <= s + 20; t++) st_valid[t] = ((t - s - 1) % 2 == 0);
        build_model(1, N);
        d2 = done_iters[2];
        s  = d2 + 3;
        st_start[s] = 1'b1;
        build_model(1, N);
        rst_t = frame_iters[3] + 4 * BYTE_CYC + 10;
        st_rst[rst_t] = 1'b1;
        s = rst_t + 3;
        st_start[s] = 1'b1;
        for (int t = s + 1; t <= s + 40; t++) st_valid[t] = 1'($urandom_range(0, 1));
        build_model(1, N);
        len = done_iters[done_iters.size()-1] + 10;
        if (len > N) len = N;
        run_scenario(1, len);

        // DECIM=3: 0..11 keeps 0,3,6,9, then a random-valid frame.
        clear_stim();
        st_start[2] = 1'b1;
        for (int k = 0; k < 12; k++) st_data[3+k] = 8'(k);
        build_model(3, N);
        d0 = done_iters[0];
        s  = d0 + 2;
        st_start[s] = 1'b1;
        for (int t = s + 1; t <= s + 60; t++) st_valid[t] = 1'($urandom_range(0, 1));
        build_model(3, N);
        len = done_iters[done_iters.size()-1] + 10;
        if (len > N) len = N;
        run_scenario(3, len);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
